// File: rtl/div_16.sv
// Multi-cycle unsigned restoring divider: 2N-bit dividend / N-bit divisor.
// Optional divide-by-zero bypass and dz flag enabled by defining DIV_16_DZ_EN.
module div_16 #(
   parameter int unsigned N = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2*N-1:0]   a,
   input  logic [N-1:0]     b,
`ifdef DIV_16_DZ_EN
   output logic             dz,
`endif
   output logic [2*N-1:0]   q,
   output logic [N-1:0]     r,
   output logic             busy,
   output logic             done
);

   localparam int unsigned QW = 2 * N;
   localparam int unsigned RW = N + 1;
   localparam int unsigned SW = N + 2;
   localparam int unsigned CW = $clog2(QW + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [QW-1:0]   a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic [RW-1:0]   rem_q, rem_d;
   logic [QW-1:0]   q_q, q_d;
   logic [N-1:0]    r_q, r_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
`ifdef DIV_16_DZ_EN
   logic            dz_q, dz_d;
`endif

   logic [SW-1:0]   shifted;
   logic [SW-1:0]   diff;
   logic            fits;

   // One restoring step: bring in the next dividend bit, trial-subtract the divisor.
   always_comb begin
      shifted = {rem_q, a_q[QW-1]};
      diff    = shifted - SW'(b_q);
      fits    = (shifted >= SW'(b_q));
   end

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      q_d     = q_q;
      r_d     = r_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef DIV_16_DZ_EN
      dz_d    = dz_q;
`endif
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               cnt_d   = '0;
               rem_d   = '0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
`ifdef DIV_16_DZ_EN
            if (b_q == '0) begin
               q_d     = '1;
               r_d     = a_q[N-1:0];
               dz_d    = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end else
`endif
            if (cnt_q == CW'(QW)) begin
               // After 2N steps the dividend register holds the quotient bits.
               q_d     = a_q;
               r_d     = rem_q[N-1:0];
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
`ifdef DIV_16_DZ_EN
               dz_d    = 1'b0;
`endif
            end else begin
               rem_d = fits ? RW'(diff) : RW'(shifted);
               a_d   = {a_q[QW-2:0], fits};
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef DIV_16_DZ_EN
         dz_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         q_q     <= q_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef DIV_16_DZ_EN
         dz_q    <= dz_d;
`endif
      end
   end

   assign q    = q_q;
   assign r    = r_q;
   assign busy = busy_q;
   assign done = done_q;
`ifdef DIV_16_DZ_EN
   assign dz   = dz_q;
`endif

endmodule
